// File: rtl/move_stack_pkg.sv
// Shared types and constants for the ant move stack: direction codes, FSM states
// and a modulo helper for the circular-buffer pointers.
package move_stack_pkg;

    localparam int MOVE_W    = 3;
    localparam int DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Single conditional subtract: callers never pass more than 2*depth-1,
    // so this works for any depth, power of two or not.
    function automatic int wrap_idx(input int idx, input int depth);
        return (idx >= depth) ? idx - depth : idx;
    endfunction

endpackage

// File: rtl/move_stack_if.sv
// Bus between the ant FSM (master) and the move stack (slave).
interface move_stack_if
    import move_stack_pkg::*;
#(
    parameter int W     = MOVE_W,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          push;
    logic          pop;
    logic [W-1:0]  move_in;
    logic          clear;
    logic          drain;

    // pop_out is qualified by pop_valid, a one-cycle pulse per emitted move.
    // There is no ready: the consumer must take every pulse on the cycle it appears.
    logic [W-1:0]  top_move;
    logic [W-1:0]  pop_out;
    logic          pop_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          overflow;
    logic          underflow;
    state_t        dbg_state;

    modport master (
        output push, pop, move_in, clear, drain,
        input  top_move, pop_out, pop_valid, count, full, empty, busy,
               overflow, underflow, dbg_state
    );

    modport slave (
        input  push, pop, move_in, clear, drain,
        output top_move, pop_out, pop_valid, count, full, empty, busy,
               overflow, underflow, dbg_state
    );

endinterface

// File: rtl/move_stack_mem.sv
// DEPTH x W register array: one synchronous write port, one combinational read port.
module move_stack_mem #(
    parameter int W     = 3,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/move_stack.sv
// Clocked LIFO of ant moves over a circular buffer (base = oldest entry), with
// overflow policy, sticky error flags, registered pop output and a drain mode.
module move_stack
    import move_stack_pkg::*;
#(
    parameter int W           = MOVE_W,
    parameter int DEPTH       = DEPTH_DEF,
    parameter bit DROP_OLDEST = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    move_stack_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state_q;
    state_t        state_nxt;
    logic [AW-1:0] base_q;
    logic [AW-1:0] base_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [W-1:0]  pop_out_q;
    logic [W-1:0]  pop_out_d;
    logic          pop_valid_q;
    logic          pop_valid_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          udf_q;
    logic          udf_d;

    logic          full;
    logic          empty;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] base_inc;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // When empty the top index is meaningless; park it on base so the read
    // address always stays inside the array.
    assign top_idx  = empty ? base_q
                            : AW'(wrap_idx(int'(base_q) + int'(count_q) - 1, DEPTH));
    // When full this lands on base, i.e. the oldest slot, which is what the
    // drop-oldest overwrite needs.
    assign push_idx = AW'(wrap_idx(int'(base_q) + int'(count_q), DEPTH));
    assign base_inc = AW'(wrap_idx(int'(base_q) + 1, DEPTH));

    move_stack_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (top_idx),
        .rdata (mem_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.clear && bus.drain && !empty) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.clear || count_q == CW'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        base_d      = base_q;
        count_d     = count_q;
        pop_out_d   = pop_out_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        mem_we      = 1'b0;
        mem_waddr   = push_idx;
        mem_wdata   = bus.move_in;

        if (bus.clear) begin
            base_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.drain) begin
                        // Drain owns the cycle; the state change is all there is to do.
                        base_d = base_q;
                    end else if (bus.push && bus.pop && !empty) begin
                        pop_out_d   = mem_rdata;
                        pop_valid_d = 1'b1;
                        mem_we      = 1'b1;
                        mem_waddr   = top_idx;
                    end else if (bus.push) begin
                        if (!full) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                            if (DROP_OLDEST) begin
                                mem_we = 1'b1;
                                base_d = base_inc;
                            end
                        end
                    end else if (bus.pop) begin
                        if (!empty) begin
                            pop_out_d   = mem_rdata;
                            pop_valid_d = 1'b1;
                            count_d     = count_q - CW'(1);
                        end else begin
                            udf_d = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    pop_out_d   = mem_rdata;
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CW'(1);
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            base_q      <= '0;
            count_q     <= '0;
            pop_out_q   <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            base_q      <= base_d;
            count_q     <= count_d;
            pop_out_q   <= pop_out_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.top_move  = empty ? '0 : mem_rdata;
    assign bus.pop_out   = pop_out_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.busy      = (state_q == ST_DRAIN);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_move_stack.sv
// Directed bench for move_stack: three instances (deep drop-oldest, shallow
// drop-oldest, shallow ignore-when-full) share one stimulus stream.
module tb_move_stack;
    import move_stack_pkg::*;

    logic       clk;
    logic       resetn;
    logic       t_push;
    logic       t_pop;
    logic [2:0] t_move_in;
    logic       t_clear;
    logic       t_drain;

    int n_vec;
    int n_miss;
    logic [2:0] exp_q[$];

    move_stack_if #(.W(3), .DEPTH(32)) ifa ();
    move_stack_if #(.W(3), .DEPTH(4))  ifb ();
    move_stack_if #(.W(3), .DEPTH(4))  ifc ();

    assign ifa.push = t_push;  assign ifa.pop = t_pop;  assign ifa.move_in = t_move_in;
    assign ifa.clear = t_clear; assign ifa.drain = t_drain;
    assign ifb.push = t_push;  assign ifb.pop = t_pop;  assign ifb.move_in = t_move_in;
    assign ifb.clear = t_clear; assign ifb.drain = t_drain;
    assign ifc.push = t_push;  assign ifc.pop = t_pop;  assign ifc.move_in = t_move_in;
    assign ifc.clear = t_clear; assign ifc.drain = t_drain;

    move_stack #(.W(3), .DEPTH(32), .DROP_OLDEST(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa.slave));
    move_stack #(.W(3), .DEPTH(4), .DROP_OLDEST(1'b1)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb.slave));
    move_stack #(.W(3), .DEPTH(4), .DROP_OLDEST(1'b0)) dut_c (
        .clk(clk), .resetn(resetn), .bus(ifc.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_push(input logic [2:0] v);
        t_push = 1'b1; t_move_in = v;
        tick();
        t_push = 1'b0;
    endtask

    task automatic do_clear();
        t_clear = 1'b1;
        tick();
        t_clear = 1'b0;
    endtask

    initial begin
        int pulses;
        int busy_n;
        n_vec = 0; n_miss = 0;
        t_pop = 1'b0; t_move_in = 3'd0; t_clear = 1'b0; t_drain = 1'b0;

        // 1: reset held two cycles with push asserted
        resetn = 1'b0; t_push = 1'b1; t_move_in = 3'd5;
        tick(); tick();
        check("rst_count",     int'(ifa.count), 0);
        check("rst_empty",     int'(ifa.empty), 1);
        check("rst_pop_valid", int'(ifa.pop_valid), 0);
        check("rst_overflow",  int'(ifa.overflow), 0);
        check("rst_underflow", int'(ifa.underflow), 0);
        check("rst_pop_out",   int'(ifa.pop_out), 0);
        check("rst_count_b",   int'(ifb.count), 0);
        resetn = 1'b1; t_push = 1'b0;

        // 2: push 3,5,7 then pop x3 -> 7,5,3
        do_push(3'd3); do_push(3'd5); do_push(3'd7);
        check("lifo_count", int'(ifa.count), 3);
        check("lifo_top",   int'(ifa.top_move), 7);
        exp_q = {3'd7, 3'd5, 3'd3};
        t_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lifo_valid", int'(ifa.pop_valid), 1);
            check("lifo_data",  int'(ifa.pop_out), int'(exp_q.pop_front()));
        end
        t_pop = 1'b0;
        check("lifo_empty", int'(ifa.empty), 1);
        tick();
        check("lifo_idle_valid", int'(ifa.pop_valid), 0);

        // 3 and 4: push 1..5 into the depth-4 stacks
        do_clear();
        for (int v = 1; v <= 4; v++) do_push(3'(v));
        check("c_full",     int'(ifc.full), 1);
        check("c_ovf_pre",  int'(ifc.overflow), 0);
        do_push(3'd5);
        check("b_full",     int'(ifb.full), 1);
        check("b_overflow", int'(ifb.overflow), 1);
        check("b_count",    int'(ifb.count), 4);
        check("b_top",      int'(ifb.top_move), 5);
        check("c_overflow", int'(ifc.overflow), 1);
        check("c_top",      int'(ifc.top_move), 4);
        check("c_count",    int'(ifc.count), 4);

        exp_q = {3'd5, 3'd4, 3'd3, 3'd2};
        pulses = 0; busy_n = 0;
        t_drain = 1'b1;
        tick();
        t_drain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ifb.busy) busy_n++;
            if (ifb.pop_valid) begin
                pulses++;
                if (exp_q.size() > 0) check("b_drain_data", int'(ifb.pop_out), int'(exp_q.pop_front()));
            end
            tick();
        end
        check("b_drain_pulses", pulses, 4);
        check("b_drain_busy",   busy_n, 4);
        check("b_drain_count",  int'(ifb.count), 0);

        // push+pop on empty acts as a plain push
        do_clear();
        t_pop = 1'b1;
        do_push(3'd4);
        t_pop = 1'b0;
        check("pp_empty_count", int'(ifa.count), 1);
        check("pp_empty_top",   int'(ifa.top_move), 4);
        check("pp_empty_udf",   int'(ifa.underflow), 0);
        check("pp_empty_valid", int'(ifa.pop_valid), 0);

        // 5: stack {2,6}, replace with 1
        do_clear();
        do_push(3'd2); do_push(3'd6);
        t_pop = 1'b1;
        do_push(3'd1);
        t_pop = 1'b0;
        check("rep_data",  int'(ifa.pop_out), 6);
        check("rep_valid", int'(ifa.pop_valid), 1);
        check("rep_top",   int'(ifa.top_move), 1);
        check("rep_count", int'(ifa.count), 2);
        t_pop = 1'b1;
        tick();
        check("rep_pop1", int'(ifa.pop_out), 1);
        tick();
        check("rep_pop2", int'(ifa.pop_out), 2);
        tick();
        t_pop = 1'b0;
        check("udf_flag",  int'(ifa.underflow), 1);
        check("udf_valid", int'(ifa.pop_valid), 0);
        check("udf_count", int'(ifa.count), 0);

        // 6: drain 8 entries, clear lands on the 3rd emission
        do_clear();
        for (int v = 0; v < 8; v++) do_push(3'(v));
        check("d8_count", int'(ifa.count), 8);
        exp_q = {3'd7, 3'd6};
        pulses = 0;
        t_drain = 1'b1;
        tick();
        t_drain = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ifa.pop_valid) begin
                pulses++;
                if (exp_q.size() > 0) check("d8_data", int'(ifa.pop_out), int'(exp_q.pop_front()));
            end
            if (i == 2) t_clear = 1'b1;
            tick();
            t_clear = 1'b0;
        end
        check("d8_pulses",  pulses, 2);
        check("d8_count0",  int'(ifa.count), 0);
        check("d8_busy",    int'(ifa.busy), 0);
        check("d8_state",   int'(ifa.dbg_state), int'(ST_IDLE));
        check("d8_udf",     int'(ifa.underflow), 0);
        check("d8_b_ovf",   int'(ifb.overflow), 0);
        check("d8_b_count", int'(ifb.count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
